// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the Execute stage.
// One radix-2 step per cycle: shift-add for MUL, restoring shift-subtract for
// UDIV/SDIV. It stalls the front of the pipe while running and strobes DoneMD
// for one cycle when the result is ready.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   StartE, OpE      start request and op select (00 MUL, 01 UDIV, 10 SDIV, 11 reserved)
//   SrcAE, SrcBE     multiplicand/dividend, multiplier/divisor
//   FlushE           cancels a pending or running operation
//   StallMD          combinational stall request for F/D/E
//   BusyMD           high while iterating
//   DoneMD           one-cycle result strobe
//   ResultMD         result; held between operations
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             BusyMD,
    output logic             DoneMD,
    output logic [WIDTH-1:0] ResultMD
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0]  OP_MUL  = 2'b00;
    localparam logic [1:0]  OP_SDIV = 2'b10;
    localparam logic [1:0]  OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;       // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   acc_q, acc_d;   // product accumulator, or partial remainder
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;   // SDIV quotient must be negated
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]   mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   quo_fix;

    // One iteration of each datapath, computed from the current registers
    always_comb begin
        mul_sum = acc_q + (b_q[0] ? a_q : '0);
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        rem_nx  = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        quo_nx  = {a_q[WIDTH-2:0], div_ge};
        quo_fix = neg_q ? -quo_nx : quo_nx;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (StartE && !FlushE) begin
                    op_d  = OpE;
                    neg_d = 1'b0;
                    acc_d = '0;
                    a_d   = SrcAE;
                    b_d   = SrcBE;
                    if (OpE == OP_RSVD || (OpE != OP_MUL && SrcBE == '0)) begin
                        state_d  = DONE;
                        result_d = '0;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(WIDTH);
                        if (OpE == OP_SDIV) begin
                            // Divide magnitudes; most-negative maps to 2^(WIDTH-1) unsigned
                            a_d   = SrcAE[WIDTH-1] ? -SrcAE : SrcAE;
                            b_d   = SrcBE[WIDTH-1] ? -SrcBE : SrcBE;
                            neg_d = SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1];
                        end
                    end
                end
            end
            RUN: begin
                if (FlushE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q == OP_MUL) begin
                        acc_d = mul_sum;
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else begin
                        acc_d = rem_nx;
                        a_d   = quo_nx;
                    end
                    // Last iteration: capture the finished result directly
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        result_d = (op_q == OP_MUL) ? mul_sum : quo_fix;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign StallMD  = ((state_q == IDLE) && StartE && !FlushE) || (state_q == RUN);
    assign BusyMD   = (state_q == RUN);
    assign DoneMD   = (state_q == DONE);
    assign ResultMD = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer at WIDTH=32: a vector table of
// operations with hand-computed results, plus sequences for flush and reset.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         StartE;
    logic [1:0]   OpE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         FlushE;
    logic         StallMD;
    logic         BusyMD;
    logic         DoneMD;
    logic [W-1:0] ResultMD;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .OpE      (OpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .FlushE   (FlushE),
        .StallMD  (StallMD),
        .BusyMD   (BusyMD),
        .DoneMD   (DoneMD),
        .ResultMD (ResultMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge (cycle 0) and hold StartE until the DONE cycle,
    // as the stalled instruction would. Cycles are sampled just after each negedge.
    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int stall_cnt;
        int done_cnt;
        int done_k;
        logic [W-1:0] res;
        stall_cnt = 0;
        done_cnt  = 0;
        done_k    = -1;
        res       = '0;
        @(negedge clk);
        StartE = 1'b1;
        OpE    = op;
        SrcAE  = a;
        SrcBE  = b;
        for (int k = 0; k <= lat + 3; k++) begin
            if (k == lat + 1) StartE = 1'b0;
            #1;
            if (StallMD) stall_cnt++;
            if (DoneMD) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    res    = ResultMD;
                end
            end
            @(negedge clk);
        end
        StartE = 1'b0;
        chk({name, "_done_cycle"}, W'(done_k), W'(lat));
        chk({name, "_done_count"}, W'(done_cnt), W'(1));
        chk({name, "_stall_cycles"}, W'(stall_cnt), W'(lat));
        chk({name, "_result"}, res, exp);
    endtask

    initial begin
        int quiet_done;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         33};
        vecs[1]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33};
        vecs[2]  = '{2'b00, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   33};
        vecs[3]  = '{2'b00, 32'h80000000,   32'd2,          32'h00000000,   33};
        vecs[4]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[5]  = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
        vecs[6]  = '{2'b01, 32'd7,          32'd100,        32'd0,          33};
        vecs[7]  = '{2'b01, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   33};
        vecs[8]  = '{2'b10, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   33};
        vecs[9]  = '{2'b10, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33};
        vecs[10] = '{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
        vecs[11] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
        vecs[12] = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33};
        vecs[13] = '{2'b01, 32'd5,          32'd0,          32'd0,          1};
        vecs[14] = '{2'b11, 32'd5,          32'd9,          32'd0,          1};
        vecs[15] = '{2'b10, 32'hFFFFFF9C,   32'd0,          32'd0,          1};

        reset  = 1'b0;
        StartE = 1'b0;
        OpE    = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        FlushE = 1'b0;

        // Reset state
        #3;
        chk("rst_busy",   W'(BusyMD),  W'(0));
        chk("rst_done",   W'(DoneMD),  W'(0));
        chk("rst_stall",  W'(StallMD), W'(0));
        chk("rst_result", ResultMD,    W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven operations
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat);
        end

        // Flush mid-RUN: start MUL, flush in cycle 10
        @(negedge clk);
        StartE = 1'b1;
        OpE    = 2'b00;
        SrcAE  = 32'd123;
        SrcBE  = 32'd456;
        for (int k = 0; k < 10; k++) @(negedge clk);
        FlushE = 1'b1;
        #1;
        chk("flush_c10_stall", W'(StallMD), W'(1));
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        chk("flush_c11_busy",  W'(BusyMD),  W'(0));
        chk("flush_c11_stall", W'(StallMD), W'(0));
        quiet_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (DoneMD) quiet_done++;
            @(negedge clk);
        end
        chk("flush_no_done", W'(quiet_done), W'(0));
        run_op("after_flush_mul", 2'b00, 32'd3, 32'd3, 32'd9, 33);

        // Flush together with start in IDLE must not start
        @(negedge clk);
        StartE = 1'b1;
        FlushE = 1'b1;
        OpE    = 2'b01;
        SrcAE  = 32'd50;
        SrcBE  = 32'd5;
        #1;
        chk("flush_start_stall", W'(StallMD), W'(0));
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        chk("flush_start_busy", W'(BusyMD), W'(0));
        chk("flush_start_done", W'(DoneMD), W'(0));

        // Flush in DONE still strobes DoneMD
        @(negedge clk);
        StartE = 1'b1;
        OpE    = 2'b01;
        SrcAE  = 32'd5;
        SrcBE  = 32'd0;
        @(negedge clk);
        FlushE = 1'b1;
        #1;
        chk("flush_in_done_strobe", W'(DoneMD),  W'(1));
        chk("flush_in_done_stall",  W'(StallMD), W'(0));
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        #1;
        chk("flush_in_done_after", W'(DoneMD), W'(0));

        // Give ResultMD a nonzero value, then reset in cycle 15 of a UDIV
        run_op("pre_reset_mul", 2'b00, 32'd11, 32'd13, 32'd143, 33);
        @(negedge clk);
        StartE = 1'b1;
        OpE    = 2'b01;
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        for (int k = 0; k < 15; k++) @(negedge clk);
        #1;
        chk("pre_reset_busy", W'(BusyMD), W'(1));
        reset  = 1'b0;
        StartE = 1'b0;
        #1;
        chk("reset_busy",   W'(BusyMD),  W'(0));
        chk("reset_done",   W'(DoneMD),  W'(0));
        chk("reset_stall",  W'(StallMD), W'(0));
        chk("reset_result", ResultMD,    W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        quiet_done = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (DoneMD || BusyMD) quiet_done++;
            @(negedge clk);
        end
        chk("reset_no_resume", W'(quiet_done), W'(0));
        run_op("after_reset_udiv", 2'b01, 32'd100, 32'd7, 32'd14, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits; legal values are even and >= 8.
REQ-002 SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-004 SHALL have port StartE, in, 1, Execute-stage instruction is a multiply/divide.
REQ-005 SHALL have port OpE, in, 2, operation select: 00 MUL (low WIDTH bits of product), 01 UDIV, 10 SDIV, 11 reserved.
REQ-006 SHALL have port SrcAE, in, WIDTH, multiplicand or dividend.
REQ-007 SHALL have port SrcBE, in, WIDTH, multiplier or divisor.
REQ-008 SHALL have port FlushE, in, 1, Execute-stage flush from the hazard unit; cancels the operation.
REQ-009 SHALL have port StallMD, out, 1, combinational request to stall F, D and E (OR-ed into StallF/StallD by the hazard unit).
REQ-010 SHALL have port BusyMD, out, 1, state is RUN.
REQ-011 SHALL have port DoneMD, out, 1, single-cycle result-valid strobe.
REQ-012 SHALL have port ResultMD, out, WIDTH, result, valid while DoneMD=1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, plus a down-counter of ceil(log2(WIDTH+1)) bits.
REQ-014 IDLE: StartE=1 and FlushE=0 SHALL latch operands and OpE; if the op is UDIV/SDIV with SrcBE=0, or OpE=11, the FSM SHALL go to DONE; otherwise it SHALL load counter=WIDTH and go to RUN.
REQ-015 RUN: the block SHALL perform one radix-2 iteration per cycle (shift-add for MUL, restoring shift-subtract for DIV) and decrement the counter; it SHALL go to DONE on the cycle the counter reaches 0, giving exactly WIDTH cycles in RUN.
REQ-016 DONE: the block SHALL assert DoneMD for one cycle, drive ResultMD and go to IDLE unconditionally; StartE in DONE is the completing instruction and SHALL NOT restart.
REQ-017 StallMD SHALL equal (state==IDLE & StartE & ~FlushE) | (state==RUN), and SHALL be 0 in DONE so the instruction advances with its result.
REQ-018 Latency: with Start accepted at edge 0, DoneMD SHALL be high in cycle WIDTH+1, and StallMD SHALL be high for exactly WIDTH+1 cycles.
REQ-019 MUL: ResultMD SHALL be (SrcAE*SrcBE) mod 2^WIDTH, identical for signed and unsigned operands.
REQ-020 UDIV: ResultMD SHALL be floor(A/B) unsigned; the remainder SHALL be discarded.
REQ-021 SDIV: the block SHALL divide the magnitudes and negate the quotient when operand signs differ, truncating toward zero; most-negative / -1 SHALL return most-negative (wrap).
REQ-022 Divide-by-zero (UDIV/SDIV) and OpE=11 SHALL return ResultMD=0 with DoneMD in the cycle after Start (2-cycle latency, StallMD high 1 cycle).
REQ-023 FlushE=1 in RUN SHALL force IDLE at the next edge with no DoneMD; FlushE with StartE in IDLE SHALL not start; flush SHALL win over start.
REQ-024 FlushE in DONE SHALL still pulse DoneMD; the consumer gates it.
REQ-025 ResultMD SHALL hold its last value outside DONE; the value is don't-care but it SHALL never be X after reset.

Reset
REQ-026 reset=0 SHALL, asynchronously, force IDLE, counter=0, all operand/accumulator registers and ResultMD to 0, and DoneMD=BusyMD=0; StallMD SHALL then follow REQ-017.
REQ-027 Reset asserted mid-RUN SHALL abort with no DoneMD; after release, the first StartE SHALL start a fresh operation.

Verification
REQ-028 MUL 7*6, WIDTH=32: DoneMD in cycle 33 with ResultMD=42, StallMD high cycles 0-32; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-029 UDIV 100/7 -> 14 at cycle 33; UDIV 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-030 SDIV -100/7 -> 0xFFFFFFF2 (-14); SDIV 100/-7 -> -14; SDIV 0x80000000/-1 -> 0x80000000.
REQ-031 UDIV 5/0 -> DoneMD in cycle 1 with ResultMD=0, StallMD high only in cycle 0; OpE=11 behaves the same.
REQ-032 Start MUL, FlushE=1 in cycle 10 -> IDLE in cycle 11, no DoneMD, StallMD=0; new MUL 3*3 issued next -> 9 after 33 cycles.
REQ-033 Reset low in cycle 15 of a UDIV -> outputs 0 immediately; no DoneMD after release.
